// File: rtl/move_replay_player.sv
// Captures one 2-bit direction per game tick into a small buffer and replays it
// later as a one-hot key vector, so a recorded run can drive a player input.
module move_replay_player #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk_slowHz,
   input  logic          rst,
   input  logic          record_start,
   input  logic          replay_start,
   input  logic          stop,
   input  logic          round_reset,
   input  logic [1:0]    dir_in,
   output logic [3:0]    key_out,
   output logic [1:0]    state,
   output logic [AW:0]   rec_len,
   output logic          full,
   output logic          done
);

   localparam logic [1:0]  ST_IDLE   = 2'b00;
   localparam logic [1:0]  ST_RECORD = 2'b01;
   localparam logic [1:0]  ST_REPLAY = 2'b10;
   localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE       = 1;

   // Commands are levels sampled on every game tick; there is no handshake.
   // stop/round_reset outrank both starts, and starts only act in IDLE.

   logic [1:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] wr_nxt;
   logic        abort;
   logic        wr_en;

   assign abort  = stop | round_reset;
   assign wr_en  = (state == ST_RECORD) && !abort;
   assign wr_nxt = wr_ptr + ONE;

   function automatic logic [3:0] to_key(input logic [1:0] d);
      case (d)
         2'b00:   to_key = 4'b1000;
         2'b01:   to_key = 4'b0001;
         2'b10:   to_key = 4'b0100;
         default: to_key = 4'b0010;
      endcase
   endfunction

   // The buffer is deliberately left out of reset; rec_len=0 hides stale data.
   always_ff @(posedge clk_slowHz) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= dir_in;
   end

   always_ff @(posedge clk_slowHz or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         key_out <= 4'b0000;
         rec_len <= '0;
         full    <= 1'b0;
         done    <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         key_out <= 4'b0000;
         done    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!abort) begin
                  if (record_start) begin
                     state   <= ST_RECORD;
                     wr_ptr  <= '0;
                     rec_len <= '0;
                     full    <= 1'b0;
                  end else if (replay_start) begin
                     if (rec_len == '0) begin
                        done <= 1'b1;
                     end else begin
                        state  <= ST_REPLAY;
                        rd_ptr <= '0;
                     end
                  end
               end
            end
            ST_RECORD: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else begin
                  wr_ptr  <= wr_nxt;
                  rec_len <= wr_nxt;
                  if (wr_nxt == DEPTH_L) begin
                     full  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_REPLAY: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (rd_ptr == rec_len) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  key_out <= to_key(mem[rd_ptr[AW-1:0]]);
                  rd_ptr  <= rd_ptr + ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
